// File: rtl/streaming_comparator.sv
// rtl/streaming_comparator.sv - block-serial magnitude comparator of two multi-block operands
// Optional macro CMP_SIGNED_EN: most-significant block compared as two's complement.
module streaming_comparator #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int MSB_FIRST     = 0,
  localparam int CW           = (NUM_BLOCKS > 2) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [REGISTER_SIZE-1:0] block_numA_in,
  input  logic [REGISTER_SIZE-1:0] block_numB_in,
  output logic [1:0]               comparison_result_out,
  output logic                     result_valid_out,
  input  logic                     result_ready_in,
  output logic [CW-1:0]            block_count_out
);

  localparam logic [1:0] RES_NULL = 2'b00;
  localparam logic [1:0] RES_LT   = 2'b01;
  localparam logic [1:0] RES_GT   = 2'b10;
  localparam logic [1:0] RES_EQ   = 2'b11;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t        state;
  logic [1:0]    result_q;
  logic [CW-1:0] count_q;
  logic          ready_q;
  logic          valid_q;

  logic          a_lt_b;
  logic          a_gt_b;
  logic          is_last;
  logic          accept;
  logic [1:0]    next_result;

  assign accept  = valid_in && ready_q;
  assign is_last = (count_q == CW'(NUM_BLOCKS - 1));

`ifdef CMP_SIGNED_EN
  logic is_ms_block;
  assign is_ms_block = (MSB_FIRST != 0) ? (count_q == '0) : is_last;

  always_comb begin
    a_lt_b = block_numA_in < block_numB_in;
    a_gt_b = block_numA_in > block_numB_in;
    if (is_ms_block) begin
      a_lt_b = $signed(block_numA_in) < $signed(block_numB_in);
      a_gt_b = $signed(block_numA_in) > $signed(block_numB_in);
    end
  end
`else
  assign a_lt_b = block_numA_in < block_numB_in;
  assign a_gt_b = block_numA_in > block_numB_in;
`endif

  // LSB-first: later (more significant) blocks override; MSB-first: first difference locks
  always_comb begin
    next_result = result_q;
    if (MSB_FIRST != 0) begin
      if (result_q != RES_LT && result_q != RES_GT)
        next_result = a_lt_b ? RES_LT : (a_gt_b ? RES_GT : RES_EQ);
    end else begin
      if (a_lt_b)
        next_result = RES_LT;
      else if (a_gt_b)
        next_result = RES_GT;
      else if (result_q == RES_NULL)
        next_result = RES_EQ;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= ACCUM;
      result_q <= RES_NULL;
      count_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            result_q <= next_result;
            if (is_last) begin
              count_q <= '0;
              state   <= HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (result_ready_in) begin
            state    <= ACCUM;
            result_q <= RES_NULL;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign ready_out             = ready_q;
  assign result_valid_out      = valid_q;
  assign comparison_result_out = result_q;
  assign block_count_out       = count_q;

endmodule

// File: tb/tb_streaming_comparator.sv
// tb/tb_streaming_comparator.sv - directed bench, LSB-first and MSB-first instances side by side
module tb_streaming_comparator;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       valid_in;
  logic       result_ready_in;
  logic [7:0] a_in;
  logic [7:0] b_in;

  logic       l_ready, l_valid, m_ready, m_valid;
  logic [1:0] l_res, m_res, l_cnt, m_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  streaming_comparator #(.REGISTER_SIZE(8), .NUM_BLOCKS(4), .MSB_FIRST(0)) u_lsb (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(l_ready),
    .block_numA_in(a_in), .block_numB_in(b_in), .comparison_result_out(l_res),
    .result_valid_out(l_valid), .result_ready_in(result_ready_in), .block_count_out(l_cnt));

  streaming_comparator #(.REGISTER_SIZE(8), .NUM_BLOCKS(4), .MSB_FIRST(1)) u_msb (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(m_ready),
    .block_numA_in(a_in), .block_numB_in(b_in), .comparison_result_out(m_res),
    .result_valid_out(m_valid), .result_ready_in(result_ready_in), .block_count_out(m_cnt));

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic handshake();
    valid_in = 1'b0;
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; valid_in = 1'b0; result_ready_in = 1'b0; a_in = '0; b_in = '0;
    #3;
    checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", l_ready); end
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", l_valid); end
    checks++; if (l_res !== 2'b00) begin errors++; $display("FAIL reset_result got %b exp 00", l_res); end
    checks++; if (l_cnt !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", l_cnt); end
    tick();
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a = 32'h07_00_00_05;
    logic [31:0] b = 32'h07_00_00_09;
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in = a[8*i +: 8]; b_in = b[8*i +: 8];
      tick();
      if (i == 0) begin
        checks++; if (l_cnt !== 2'd1) begin errors++; $display("FAIL b2b_count1 got %0d exp 1", l_cnt); end
        checks++; if (l_res !== 2'b01) begin errors++; $display("FAIL b2b_running got %b exp 01", l_res); end
      end
      if (i == 2) begin
        checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_mid got %b exp 1", l_ready); end
      end
    end
    valid_in = 1'b0;
    checks++; if (l_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got %b exp 0", l_ready); end
    checks++; if (l_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", l_valid); end
    checks++; if (l_res !== 2'b01) begin errors++; $display("FAIL b2b_result got %b exp 01", l_res); end
    checks++; if (l_cnt !== 2'd0) begin errors++; $display("FAIL b2b_count_clear got %0d exp 0", l_cnt); end
    checks++; if (m_res !== 2'b01) begin errors++; $display("FAIL b2b_msb_result got %b exp 01", m_res); end
    handshake();
    checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL hs_ready got %b exp 1", l_ready); end
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL hs_valid got %b exp 0", l_valid); end
    checks++; if (l_res !== 2'b00) begin errors++; $display("FAIL hs_result got %b exp 00", l_res); end
  endtask

  task automatic test_msb_lock();
    logic [31:0] a = 32'hFF_FF_FF_10;
    logic [31:0] b = 32'h00_00_00_20;
    logic [1:0]  lsb_exp;
`ifdef CMP_SIGNED_EN
    lsb_exp = 2'b01;
`else
    lsb_exp = 2'b10;
`endif
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in = a[8*i +: 8]; b_in = b[8*i +: 8];
      tick();
      if (i == 0) begin
        checks++; if (m_res !== 2'b01) begin errors++; $display("FAIL lock_first got %b exp 01", m_res); end
      end
      if (i == 1) begin
        checks++; if (m_res !== 2'b01) begin errors++; $display("FAIL lock_held got %b exp 01", m_res); end
        checks++; if (l_res !== 2'b10) begin errors++; $display("FAIL lsb_override got %b exp 10", l_res); end
      end
    end
    valid_in = 1'b0;
    checks++; if (m_res !== 2'b01) begin errors++; $display("FAIL lock_final got %b exp 01", m_res); end
    checks++; if (l_res !== lsb_exp) begin errors++; $display("FAIL lsb_final got %b exp %b", l_res, lsb_exp); end
    handshake();
  endtask

  task automatic test_gap();
    logic [31:0] d = 32'hDD_CC_BB_AA;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; a_in = d[8*i +: 8]; b_in = d[8*i +: 8];
      tick();
      valid_in = 1'b0;
      if (i == 1) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          checks++; if (l_cnt !== 2'd2) begin errors++; $display("FAIL gap_count got %0d exp 2", l_cnt); end
          checks++; if (l_res !== 2'b11) begin errors++; $display("FAIL gap_result got %b exp 11", l_res); end
        end
      end
    end
    checks++; if (l_res !== 2'b11) begin errors++; $display("FAIL gap_lsb_final got %b exp 11", l_res); end
    checks++; if (m_res !== 2'b11) begin errors++; $display("FAIL gap_msb_final got %b exp 11", m_res); end
  endtask

  task automatic test_hold_stall();
    valid_in = 1'b1; a_in = 8'h01; b_in = 8'h02; result_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (l_res !== 2'b11) begin errors++; $display("FAIL stall_result got %b exp 11", l_res); end
      checks++; if (l_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", l_ready); end
      checks++; if (l_cnt !== 2'd0) begin errors++; $display("FAIL stall_count got %0d exp 0", l_cnt); end
    end
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", l_ready); end
    checks++; if (l_cnt !== 2'd0) begin errors++; $display("FAIL release_no_accept got %0d exp 0", l_cnt); end
    checks++; if (l_res !== 2'b00) begin errors++; $display("FAIL release_result got %b exp 00", l_res); end
    tick();
    checks++; if (l_cnt !== 2'd1) begin errors++; $display("FAIL release_next got %0d exp 1", l_cnt); end
    for (int i = 0; i < 3; i++) tick();
    valid_in = 1'b0;
    checks++; if (l_valid !== 1'b1) begin errors++; $display("FAIL stall_op2_valid got %b exp 1", l_valid); end
    checks++; if (l_res !== 2'b01) begin errors++; $display("FAIL stall_op2_result got %b exp 01", l_res); end
    handshake();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a = 32'h04_03_02_01;
    logic [31:0] b = 32'h05_03_02_01;
    valid_in = 1'b1; a_in = 8'hFF; b_in = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    valid_in = 1'b0;
    checks++; if (l_cnt !== 2'd3) begin errors++; $display("FAIL mid_count got %0d exp 3", l_cnt); end
    #2 rst_in = 1'b1;
    #1;
    checks++; if (l_cnt !== 2'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", l_cnt); end
    checks++; if (l_res !== 2'b00) begin errors++; $display("FAIL mid_rst_result got %b exp 00", l_res); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", m_ready); end
    #1 rst_in = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in = a[8*i +: 8]; b_in = b[8*i +: 8];
      tick();
    end
    valid_in = 1'b0;
    checks++; if (l_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b exp 1", l_valid); end
    checks++; if (l_res !== 2'b01) begin errors++; $display("FAIL post_rst_lsb got %b exp 01", l_res); end
    checks++; if (m_res !== 2'b01) begin errors++; $display("FAIL post_rst_msb got %b exp 01", m_res); end
    handshake();
  endtask

  task automatic test_reset_hold();
    valid_in = 1'b1; a_in = 8'h00; b_in = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    valid_in = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rhold_valid got %b exp 1", m_valid); end
    #2 rst_in = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rhold_drop got %b exp 0", m_valid); end
    checks++; if (m_res !== 2'b00) begin errors++; $display("FAIL rhold_result got %b exp 00", m_res); end
    #1 rst_in = 1'b0;
    tick();
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rhold_ready got %b exp 1", m_ready); end
  endtask

  task automatic test_signed();
    logic [31:0] a = 32'h80_00_00_00;
    logic [31:0] b = 32'h01_00_00_00;
    logic [1:0]  lsb_exp;
`ifdef CMP_SIGNED_EN
    lsb_exp = 2'b01;
`else
    lsb_exp = 2'b10;
`endif
    result_ready_in = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in = a[8*i +: 8]; b_in = b[8*i +: 8];
      tick();
    end
    valid_in = 1'b0;
    checks++; if (l_valid !== 1'b1) begin errors++; $display("FAIL signed_valid got %b exp 1", l_valid); end
    checks++; if (l_res !== lsb_exp) begin errors++; $display("FAIL signed_lsb got %b exp %b", l_res, lsb_exp); end
    checks++; if (m_res !== 2'b10) begin errors++; $display("FAIL signed_msb got %b exp 10", m_res); end
    tick();
    result_ready_in = 1'b0;
    checks++; if (l_ready !== 1'b1) begin errors++; $display("FAIL signed_release got %b exp 1", l_ready); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_msb_lock();
    test_gap();
    test_hold_stall();
    test_reset_mid();
    test_reset_hold();
    test_signed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
